// File: rtl/iaf_neuron_pkg.sv
// Shared definitions for the integrate-and-fire neuron.
// Holds the synaptic weight width and helpers that size the per-cycle
// increment and the saturation ceiling of the membrane potential.
package iaf_neuron_pkg;

  // Each synapse carries a two-bit weight {high, low}.
  localparam int unsigned WEIGHT_W   = 2;
  localparam int unsigned WEIGHT_MAX = 3;

  // Width needed to hold the largest possible increment, 3*inputs.
  function automatic int unsigned inc_width(input int unsigned inputs);
    return $clog2(WEIGHT_MAX * inputs + 1);
  endfunction

  // Largest value representable in a vw-bit membrane register.
  function automatic longint unsigned sat_max(input int unsigned vw);
    return (64'd1 << vw) - 64'd1;
  endfunction

endpackage

// File: rtl/iaf_neuron_weighted_sum.sv
// iaf_weighted_sum: combinational weighted popcount.
// Ports:
//   weight_low_bits_i  - bit 0 of each synapse weight
//   weight_high_bits_i - bit 1 of each synapse weight
//   signals_i          - per-synapse activity this cycle
//   inc_o              - sum of weights over active synapses
module iaf_weighted_sum
  import iaf_neuron_pkg::*;
#(
  parameter int unsigned INPUTS = 5,
  localparam int unsigned IW = inc_width(INPUTS)
) (
  input  logic [INPUTS-1:0] weight_low_bits_i,
  input  logic [INPUTS-1:0] weight_high_bits_i,
  input  logic [INPUTS-1:0] signals_i,
  output logic [IW-1:0]     inc_o
);

  logic [IW-1:0] sum_s;

  // Accumulate the two-bit weight of every active synapse.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < int'(INPUTS); i++) begin
      if (signals_i[i]) begin
        sum_s = sum_s + IW'({weight_high_bits_i[i], weight_low_bits_i[i]});
      end else begin
        sum_s = sum_s;
      end
    end
  end

  assign inc_o = sum_s;

endmodule

// File: rtl/iaf_neuron.sv
// iaf_neuron: integrate-and-fire neuron with saturating membrane potential.
// Ports:
//   clk              - rising-edge clock
//   rstb             - asynchronous active-low reset (clears vmem, spike, fired)
//   weight_low_bits  - bit 0 of each synapse weight
//   weight_high_bits - bit 1 of each synapse weight
//   signals          - per-synapse activity this cycle
//   trig             - integrate enable
//   re               - read / fire-evaluate enable
//   spike            - registered: re & (vmem >= VT) from the previous edge
//   fired            - sticky: set whenever spike is produced, cleared by reset
module iaf_neuron
  import iaf_neuron_pkg::*;
#(
  parameter int unsigned INPUTS = 5,
  parameter int unsigned VT     = 5,
  parameter int unsigned VW     = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [INPUTS-1:0] weight_low_bits,
  input  logic [INPUTS-1:0] weight_high_bits,
  input  logic [INPUTS-1:0] signals,
  input  logic              trig,
  input  logic              re,
  output logic              spike,
  output logic              fired
);

  localparam int unsigned IW = inc_width(INPUTS);
  // Sum width wide enough for either operand plus a carry bit.
  localparam int unsigned SW = ((VW > IW) ? VW : IW) + 1;
  localparam logic [VW-1:0] VMAX = VW'(sat_max(VW));
  localparam logic [VW-1:0] VT_V = VW'(VT);

  logic [IW-1:0] inc_s;
  logic [SW-1:0] sum_s;
  logic [VW-1:0] vmem_d;
  logic [VW-1:0] vmem_q;
  logic          fire_s;
  logic          spike_q;
  logic          fired_q;

  iaf_weighted_sum #(
    .INPUTS (INPUTS)
  ) u_weighted_sum (
    .weight_low_bits_i  (weight_low_bits),
    .weight_high_bits_i (weight_high_bits),
    .signals_i          (signals),
    .inc_o              (inc_s)
  );

  // Saturating integrate: clamp at VMAX instead of wrapping.
  always_comb begin
    sum_s  = SW'(vmem_q) + SW'(inc_s);
    vmem_d = vmem_q;
    if (trig) begin
      if (sum_s > SW'(VMAX)) begin
        vmem_d = VMAX;
      end else begin
        vmem_d = sum_s[VW-1:0];
      end
    end else begin
      vmem_d = vmem_q;
    end
  end

  // Fire decision uses the pre-edge potential, so a same-cycle integrate
  // only becomes visible to the next read.
  assign fire_s = re & (vmem_q >= VT_V);

  // Membrane, spike and sticky fired registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vmem_q  <= '0;
      spike_q <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      vmem_q  <= vmem_d;
      spike_q <= fire_s;
      fired_q <= fired_q | fire_s;
    end
  end

  assign spike = spike_q;
  assign fired = fired_q;

endmodule

// File: tb/tb_iaf_neuron.sv
// Self-checking bench for iaf_neuron: directed test-plan steps followed by
// randomized stimulus, compared against an arithmetic reference model.
// Two instances share stimulus: default VW=8 and a narrow VW=4 copy that
// exercises saturation.
module tb_iaf_neuron;

  localparam int N   = 5;
  localparam int VTH = 5;

  logic         clk;
  logic         rstb;
  logic [N-1:0] wl;
  logic [N-1:0] wh;
  logic [N-1:0] sig;
  logic         trig;
  logic         re;
  logic         spike8, fired8, spike4, fired4;

  int checks = 0;
  int fails  = 0;

  // Reference model state.
  int vm8, vm4;
  int sp8, sp4, fd8, fd4;

  iaf_neuron #(.INPUTS(N), .VT(VTH), .VW(8)) dut8 (
    .clk(clk), .rstb(rstb), .weight_low_bits(wl), .weight_high_bits(wh),
    .signals(sig), .trig(trig), .re(re), .spike(spike8), .fired(fired8)
  );

  iaf_neuron #(.INPUTS(N), .VT(VTH), .VW(4)) dut4 (
    .clk(clk), .rstb(rstb), .weight_low_bits(wl), .weight_high_bits(wh),
    .signals(sig), .trig(trig), .re(re), .spike(spike4), .fired(fired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_inc();
    int s = 0;
    for (int i = 0; i < N; i++)
      if (sig[i]) s += 2 * int'(wh[i]) + int'(wl[i]);
    return s;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/vmem8"},  int'(dut8.vmem_q), vm8);
    check({tag, "/spike8"}, int'(spike8),      sp8);
    check({tag, "/fired8"}, int'(fired8),      fd8);
    check({tag, "/vmem4"},  int'(dut4.vmem_q), vm4);
    check({tag, "/spike4"}, int'(spike4),      sp4);
    check({tag, "/fired4"}, int'(fired4),      fd4);
  endtask

  task automatic model_clear();
    vm8 = 0; vm4 = 0; sp8 = 0; sp4 = 0; fd8 = 0; fd4 = 0;
  endtask

  // One clock: model follows the specification on the edge, then compare.
  task automatic step(input string tag);
    int inc;
    @(posedge clk);
    inc = model_inc();
    sp8 = (re && vm8 >= VTH) ? 1 : 0;
    sp4 = (re && vm4 >= VTH) ? 1 : 0;
    fd8 = fd8 | sp8;
    fd4 = fd4 | sp4;
    if (trig) begin
      vm8 = sat(vm8 + inc, 255);
      vm4 = sat(vm4 + inc, 15);
    end
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Mid-cycle reset pulse: outputs must clear before any clock edge.
  task automatic reset_pulse(input string tag);
    #2;
    rstb = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic drive(input logic [N-1:0] l, input logic [N-1:0] h,
                       input logic [N-1:0] s, input logic t, input logic r);
    wl = l; wh = h; sig = s; trig = t; re = r;
  endtask

  initial begin
    rstb = 1'b0;
    drive(5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset");
    rstb = 1'b1;

    // Zero weights: integrate does nothing, read never fires.
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("zero_trig");
    drive(5'b00000, 5'b00000, 5'b11111, 1'b1, 1'b0);
    step("zero_w_sig");
    drive(5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("zero_read");
    check("zero_vmem_const", int'(dut8.vmem_q), 0);

    // Full drive: one cycle of 5 x weight 3 gives 15, then fire.
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);
    step("full_trig");
    check("full_vmem15", int'(dut8.vmem_q), 15);
    drive(5'b11111, 5'b11111, 5'b11111, 1'b0, 1'b1);
    step("full_read");
    check("full_spike", int'(spike8), 1);
    reset_pulse("full_rst");

    // Threshold boundary: 4 is below VT, 5 fires.
    drive(5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("thr_trig");
    drive(5'b00001, 5'b00000, 5'b00001, 1'b0, 1'b1);
    step("thr_read4");
    check("thr_spike_at4", int'(spike8), 0);
    drive(5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0);
    step("thr_trig5");
    drive(5'b00001, 5'b00000, 5'b00001, 1'b0, 1'b1);
    step("thr_read5");
    check("thr_spike_at5", int'(spike8), 1);
    reset_pulse("thr_rst");

    // Saturation: three full cycles -> 45 on VW=8, clamped 15 on VW=4.
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("sat_trig");
    check("sat_vmem4", int'(dut4.vmem_q), 15);
    check("sat_vmem8", int'(dut8.vmem_q), 45);
    reset_pulse("sat_rst");

    // Simultaneous trig and read: compare sees old vmem.
    drive(5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("sim_pre");
    drive(5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b1);
    step("sim_both");
    check("sim_first_spike", int'(spike8), 0);
    drive(5'b00001, 5'b00000, 5'b00001, 1'b0, 1'b1);
    step("sim_next");
    check("sim_next_spike", int'(spike8), 1);
    drive(5'b00001, 5'b00000, 5'b00001, 1'b0, 1'b0);
    step("spike_drop");

    // Async reset mid-read while spike is high.
    drive(5'b00001, 5'b00000, 5'b00001, 1'b0, 1'b1);
    step("ar_read");
    check("ar_spike_before", int'(spike8), 1);
    reset_pulse("ar_rst");

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      drive(N'($urandom), N'($urandom), N'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) reset_pulse("rnd_rst");
      else step("rnd");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
